// File: rtl/ucsbece154b_icache_pf.sv
// Direct-mapped instruction cache with a one-line next-line prefetch buffer.
// Hits are served combinationally; misses stall fetch while a burst refills.
module ucsbece154b_icache_pf #(
    parameter int NUM_SETS       = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadAddress_i,
    output logic [31:0] Instr_o,
    output logic        Ready_o,
    output logic [31:0] MemReadAddress_o,
    output logic        MemReadRequest_o,
    input  logic [31:0] MemDataIn_i,
    input  logic        MemDataReady_i
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int LA_W  = 30 - OFF_W;
    localparam int TAG_W = LA_W - IDX_W;

    typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;
    typedef enum logic [1:0] { IDLE, FILL, PREFETCH } state_t;

    state_t            state_q, state_d;
    logic [LA_W-1:0]   base_q, base_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              bvalid_q, bvalid_d;
    logic [LA_W-1:0]   bla_q, bla_d;
    line_t             bdata_q;
    line_t             fill_q;
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q [NUM_SETS];
    line_t             data_q [NUM_SETS];

    logic [LA_W-1:0]   la;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  fidx;
    logic              chit, bhit, last;
    logic              fill_we, pf_we;
    line_t             fill_line;
    logic [1:0]        unused_addr;

    assign la          = ReadAddress_i[31:OFF_W+2];
    assign idx         = la[IDX_W-1:0];
    assign tag         = la[LA_W-1:IDX_W];
    assign off         = ReadAddress_i[OFF_W+1:2];
    assign fidx        = base_q[IDX_W-1:0];
    assign unused_addr = ReadAddress_i[1:0];

    // Cache wins over the buffer; the buffer only answers on a cache miss.
    assign chit = valid_q[idx] && (tag_q[idx] == tag);
    assign bhit = !chit && bvalid_q && (bla_q == la);
    assign last = MemDataReady_i
               && (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

    always_comb begin
        fill_line = fill_q;
        fill_line[WORDS_PER_LINE-1] = MemDataIn_i;
    end

    assign Ready_o          = !reset && (chit || bhit);
    assign MemReadRequest_o = req_q && !reset;
    assign MemReadAddress_o = {base_q, {(OFF_W+2){1'b0}}};

    always_comb begin
        Instr_o = '0;
        if (!reset && chit)
            Instr_o = data_q[idx][off];
        else if (!reset && bhit)
            Instr_o = bdata_q[off];
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        req_d    = 1'b0;
        bvalid_d = bvalid_q;
        bla_d    = bla_q;
        fill_we  = 1'b0;
        pf_we    = 1'b0;
        if (bhit)
            bvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bhit) begin
                    state_d = PREFETCH;
                    base_d  = la + LA_W'(1);
                    cnt_d   = '0;
                    req_d   = 1'b1;
                end else if (!chit) begin
                    state_d = FILL;
                    base_d  = la;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                end
            end
            FILL: begin
                if (MemDataReady_i)
                    cnt_d = cnt_q + OFF_W'(1);
                if (last) begin
                    fill_we = 1'b1;
                    // Only keep streaming if fetch is still on this line.
                    if (la == base_q) begin
                        state_d = PREFETCH;
                        base_d  = base_q + LA_W'(1);
                        cnt_d   = '0;
                        req_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            PREFETCH: begin
                if (req_q)
                    bvalid_d = 1'b0;
                if (MemDataReady_i) begin
                    pf_we = 1'b1;
                    cnt_d = cnt_q + OFF_W'(1);
                end
                if (last) begin
                    bvalid_d = 1'b1;
                    bla_d    = base_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bla_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            bvalid_q <= bvalid_d;
            bla_q    <= bla_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (bhit) begin
                valid_q[idx] <= 1'b1;
                tag_q[idx]   <= tag;
                data_q[idx]  <= bdata_q;
            end
            if (fill_we) begin
                valid_q[fidx] <= 1'b1;
                tag_q[fidx]   <= base_q[LA_W-1:IDX_W];
                data_q[fidx]  <= fill_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (MemDataReady_i && state_q == FILL)
            fill_q[cnt_q] <= MemDataIn_i;
        if (pf_we)
            bdata_q[cnt_q] <= MemDataIn_i;
    end

endmodule
